str_rep_sequencer: RTL and testbench

Sequences a packed Verilog-style string register (8 bits per char, last char in bits [7:0]) out as a byte stream, replicating it a programmed number of times, i.e. the hardware equivalent of emitting {rep{"str"}} one character at a time. It sits between a wide string/concatenation register and a character sink such as a display or UART FIFO. A valid/ready handshake on the output side throttles it.

---
 rtl/str_rep_sequencer.sv | 122 ++++++++++++
 tb/tb_str_rep_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/str_rep_sequencer.sv
// Streams a packed string register out one byte at a time, repeated a programmed
// number of times, behind a valid/ready handshake.
module str_rep_sequencer #(
  parameter int MAXCH = 20,
  parameter int CW    = 5,
  parameter int RW    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [8*MAXCH-1:0]    str_in,
  input  logic [CW-1:0]         len,
  input  logic [RW-1:0]         rep,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_char,
  output logic                  out_last,
  output logic                  done,
  output logic [CW+RW-1:0]      count
);

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_DONE} state_t;

  state_t               state;
  logic [8*MAXCH-1:0]   str_r;
  logic [CW-1:0]        len_r;
  logic [RW-1:0]        rep_left;
  logic [CW-1:0]        idx;

  logic [CW-1:0]        len_clamp;
  logic [CW-1:0]        nxt_idx;
  logic [RW-1:0]        nxt_rep;
  logic                 at_end;
  logic                 xfer;

  // Char k of an l-char string lives at bits [8*(l-k)-1 -: 8].
  function automatic logic [7:0] char_at(input logic [8*MAXCH-1:0] s,
                                         input logic [CW-1:0] l,
                                         input logic [CW-1:0] k);
    logic [8*MAXCH-1:0] sh;
    sh = s >> (8 * (int'(l) - int'(k) - 1));
    return sh[7:0];
  endfunction

  function automatic logic [CW-1:0] clamp_len(input logic [CW-1:0] l);
    return (l > CW'(MAXCH)) ? CW'(MAXCH) : l;
  endfunction

  always_comb begin
    len_clamp = clamp_len(len);
    xfer      = out_valid && out_ready;
    at_end    = (idx == len_r - 1'b1);
    nxt_idx   = idx + 1'b1;
    nxt_rep   = rep_left;
    if (at_end) begin
      nxt_idx = '0;
      nxt_rep = rep_left - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      str_r     <= '0;
      len_r     <= '0;
      rep_left  <= '0;
      idx       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_char  <= 8'h00;
      out_last  <= 1'b0;
      done      <= 1'b0;
      count     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            str_r    <= str_in;
            len_r    <= len_clamp;
            rep_left <= rep;
            idx      <= '0;
            count    <= '0;
            busy     <= 1'b1;
            if (len_clamp == '0 || rep == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state     <= S_EMIT;
              out_valid <= 1'b1;
              out_char  <= char_at(str_in, len_clamp, '0);
              out_last  <= (rep == RW'(1)) && (len_clamp == CW'(1));
            end
          end
        end
        S_EMIT: begin
          if (xfer) begin
            count <= count + 1'b1;
            if (at_end && rep_left == RW'(1)) begin
              state     <= S_DONE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
            end else begin
              idx      <= nxt_idx;
              rep_left <= nxt_rep;
              out_char <= char_at(str_r, len_r, nxt_idx);
              out_last <= (nxt_rep == RW'(1)) && (nxt_idx == len_r - 1'b1);
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_str_rep_sequencer.sv
// Table-driven bench for str_rep_sequencer plus a hand-written mid-run reset sequence.
module tb_str_rep_sequencer;

  localparam int MAXCH = 20;
  localparam int CW    = 5;
  localparam int RW    = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic [8*MAXCH-1:0]   str_in;
  logic [CW-1:0]        len;
  logic [RW-1:0]        rep;
  logic                 busy;
  logic                 out_valid;
  logic                 out_ready;
  logic [7:0]           out_char;
  logic                 out_last;
  logic                 done;
  logic [CW+RW-1:0]     count;

  int checks = 0;
  int failures = 0;

  str_rep_sequencer #(.MAXCH(MAXCH), .CW(CW), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .str_in(str_in), .len(len), .rep(rep),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_char(out_char),
    .out_last(out_last), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  // mode 0: ready always 1; mode 1: ready 1,0,0 repeating; mode 2: start held high, ready 1
  typedef struct {
    logic [8*MAXCH-1:0] str;
    logic [CW-1:0]      len;
    logic [RW-1:0]      rep;
    int                 mode;
    logic [8*40-1:0]    exp;
    int                 n;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] exp_char(input logic [8*40-1:0] e, input int n, input int k);
    logic [8*40-1:0] sh;
    sh = e >> (8 * (n - k - 1));
    return sh[7:0];
  endfunction

  task automatic run_vec(input vec_t v);
    int got;
    int dones;
    int c_last;
    int c_done;
    logic pv, pr, pl;
    logic [7:0] pc;
    logic [CW+RW-1:0] pcnt;
    got = 0; dones = 0; c_last = -1; c_done = -1;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pc = 8'h00; pcnt = '0;
    str_in = v.str; len = v.len; rep = v.rep; start = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = (v.mode == 2);
    chk("busy_after_start", busy, 1'b1);
    if (v.n > 0) chk("first_valid_latency", out_valid, 1'b1);
    for (int c = 0; c < 2000; c++) begin
      out_ready = (v.mode == 1) ? (c % 3 == 0) : 1'b1;
      if (pv && !pr) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_char", out_char, pc);
        chk("stall_last", out_last, pl);
        chk("stall_count", count, pcnt);
      end
      if (out_valid && out_ready) begin
        if (got < v.n) begin
          chk("char", out_char, exp_char(v.exp, v.n, got));
          chk("last", out_last, got == v.n - 1);
        end
        got++;
        c_last = c;
      end
      if (done) begin
        dones++;
        if (c_done < 0) c_done = c;
        start = 1'b0;
        chk("done_no_valid", out_valid, 1'b0);
        chk("done_busy", busy, 1'b1);
        chk("done_count", count, v.n);
      end
      pv = out_valid; pr = out_ready; pc = out_char; pl = out_last; pcnt = count;
      if (c_done >= 0 && c > c_done) break;
      @(posedge clk); #1;
    end
    chk("char_total", got, v.n);
    chk("done_pulses", dones, 1);
    chk("done_timing", c_done, c_last + 1);
    chk("idle_busy", busy, 1'b0);
    chk("idle_done", done, 1'b0);
    chk("final_count", count, v.n);
    // a few more idle cycles: nothing should restart or pulse
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("idle_quiet", {busy, out_valid, done}, 3'b000);
    end
  endtask

  initial begin
    vecs[0] = '{str: "XYZ:", len: 4, rep: 4, mode: 0, exp: "XYZ:XYZ:XYZ:XYZ:", n: 16};
    vecs[1] = '{str: "abcd ", len: 5, rep: 2, mode: 1, exp: "abcd abcd ", n: 10};
    vecs[2] = '{str: "QRS", len: 0, rep: 3, mode: 0, exp: '0, n: 0};
    vecs[3] = '{str: "WXYZ", len: 4, rep: 0, mode: 0, exp: '0, n: 0};
    vecs[4] = '{str: "AB", len: 2, rep: 3, mode: 2, exp: "ABABAB", n: 6};
    vecs[5] = '{str: "hello world! hello w", len: 25, rep: 1, mode: 0,
                exp: "hello world! hello w", n: 20};
    vecs[6] = '{str: 160'h410042, len: 3, rep: 2, mode: 1, exp: 320'h410042410042, n: 6};
    vecs[7] = '{str: "Z", len: 1, rep: 15, mode: 1, exp: "ZZZZZZZZZZZZZZZ", n: 15};

    rst_n = 1'b0; start = 1'b0; str_in = '0; len = '0; rep = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", {busy, out_valid, out_last, done}, 4'b0000);
    chk("rst_char", out_char, 8'h00);
    chk("rst_count", count, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Mid-sequence async reset after 3 of 8 chars
    str_in = "ABCDEFGH"; len = 8; rep = 1; start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("pre_rst_char", out_char, "D");
    chk("pre_rst_count", count, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_last", out_last, 1'b0);
    chk("async_rst_count", count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk("post_rst_quiet", {busy, out_valid, done}, 3'b000);
      @(posedge clk); #1;
    end
    run_vec(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
